// File: rtl/ctrl_pipe.sv
// ctrl_pipe: chain of NSTAGE control-bundle registers with upstream-propagating stall,
// per-stage flush, and a registered count of in-flight valid entries whose TRACK_BIT is set.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-low reset
//   ctrl_d    decoded control bundle entering stage 0
//   valid_d   ctrl_d carries a real instruction
//   stall     per-stage hold request (bit 0 = first register stage)
//   flush     per-stage kill, turns the stage into a bubble at the next edge
//   ctrl_q    registered bundles, stage k at [k*WIDTH +: WIDTH]
//   valid_q   registered valid per stage
//   stall_d   decode must hold its outputs this cycle (combinational)
//   pend_cnt  registered number of valid stages with bundle bit TRACK_BIT set
//   pend_any  registered, pend_cnt != 0
module ctrl_pipe #(
  parameter int unsigned NSTAGE    = 3,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TRACK_BIT = 0,
  parameter bit          CLR_DATA  = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                ctrl_d,
  input  logic                            valid_d,
  input  logic [NSTAGE-1:0]               stall,
  input  logic [NSTAGE-1:0]               flush,
  output logic [NSTAGE*WIDTH-1:0]         ctrl_q,
  output logic [NSTAGE-1:0]               valid_q,
  output logic                            stall_d,
  output logic [$clog2(NSTAGE+1)-1:0]     pend_cnt,
  output logic                            pend_any
);

  localparam int unsigned CntW = $clog2(NSTAGE + 1);

  logic [WIDTH-1:0]  ctrlReg  [NSTAGE];
  logic [WIDTH-1:0]  ctrlNext [NSTAGE];
  logic [WIDTH-1:0]  srcCtrl  [NSTAGE];
  logic [NSTAGE-1:0] validReg;
  logic [NSTAGE-1:0] validNext;
  logic [NSTAGE-1:0] srcValid;
  logic [NSTAGE-1:0] holdVec;
  logic [NSTAGE-1:0] srcHold;
  logic [CntW-1:0]   cntReg;
  logic [CntW-1:0]   cntNext;
  logic              anyReg;

  // holdVec[k]: any stage at or downstream of k is stalling.
  always_comb begin
    holdVec = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      holdVec[k] = |(stall >> k);
    end
  end

  assign stall_d = holdVec[0];

  // Source of each stage: decode for stage 0, previous register otherwise.
  // srcHold[k] means the source is frozen and cannot hand anything over.
  always_comb begin
    srcCtrl[0]  = ctrl_d;
    srcValid[0] = valid_d;
    srcHold[0]  = 1'b0;
    for (int k = 1; k < NSTAGE; k++) begin
      srcCtrl[k]  = ctrlReg[k-1];
      srcValid[k] = validReg[k-1];
      srcHold[k]  = holdVec[k-1];
    end
  end

  // Priority: flush, own hold, bubble from frozen source, normal advance.
  always_comb begin
    validNext = validReg;
    for (int k = 0; k < NSTAGE; k++) begin
      ctrlNext[k] = ctrlReg[k];
      if (flush[k] || (!holdVec[k] && srcHold[k])) begin
        validNext[k] = 1'b0;
        ctrlNext[k]  = CLR_DATA ? '0 : ctrlReg[k];
      end else if (!holdVec[k]) begin
        validNext[k] = srcValid[k];
        ctrlNext[k]  = srcCtrl[k];
      end
    end
  end

  // Count from next-state so the registered count never lags the pipeline.
  always_comb begin
    cntNext = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      cntNext = cntNext + CntW'(validNext[k] & ctrlNext[k][TRACK_BIT]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        ctrlReg[k] <= '0;
      end
      validReg <= '0;
      cntReg   <= '0;
      anyReg   <= 1'b0;
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        ctrlReg[k] <= ctrlNext[k];
      end
      validReg <= validNext;
      cntReg   <= cntNext;
      anyReg   <= |cntNext;
    end
  end

  always_comb begin
    ctrl_q = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      ctrl_q[k*WIDTH +: WIDTH] = ctrlReg[k];
    end
  end

  assign valid_q  = validReg;
  assign pend_cnt = cntReg;
  assign pend_any = anyReg;

endmodule
